// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle for the ALU/MDU.
// The master drives operations and takes results; the slave is the ALU/MDU.
interface alu_mdu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     Busy;

  modport master (
    output in_valid, SrcA, SrcB, Operation, out_ready,
    input  in_ready, out_valid, ALUResult, Busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, out_ready,
    output in_ready, out_valid, ALUResult, Busy
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative multiplier and (optional) divider.
// Define ALU_MDU_DIV_EN to build the radix-2 restoring divider; without it
// the DIV/DIVU/REM/REMU codes behave as unsupported opcodes (result 0).
module alu_mdu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic      clk,
  input  logic      reset,
  alu_mdu_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND    = OPCODE_LENGTH'(5'b00000);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR    = OPCODE_LENGTH'(5'b00001);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB    = OPCODE_LENGTH'(5'b00010);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR     = OPCODE_LENGTH'(5'b00011);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD    = OPCODE_LENGTH'(5'b00100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SGE    = OPCODE_LENGTH'(5'b00101);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE     = OPCODE_LENGTH'(5'b00110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA    = OPCODE_LENGTH'(5'b00111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ     = OPCODE_LENGTH'(5'b01000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL    = OPCODE_LENGTH'(5'b01001);
  localparam logic [OPCODE_LENGTH-1:0] OP_PASSB  = OPCODE_LENGTH'(5'b01010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL    = OPCODE_LENGTH'(5'b01100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT    = OPCODE_LENGTH'(5'b01110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU   = OPCODE_LENGTH'(5'b01111);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(5'b10000);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(5'b10001);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(5'b10010);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU  = OPCODE_LENGTH'(5'b10011);
`ifdef ALU_MDU_DIV_EN
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(5'b10100);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(5'b10101);
  localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(5'b10110);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = OPCODE_LENGTH'(5'b10111);
`endif

  logic [1:0]               r_state;
  logic [DW-1:0]            r_result;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [CW-1:0]            r_cnt;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic [2*DW-1:0]          r_mcand;
  logic [DW-1:0]            r_mplier;
  logic [2*DW-1:0]          r_acc;
  logic                     r_neg;

  logic [DW-1:0]            w_a;
  logic [DW-1:0]            w_b;
  logic [SW-1:0]            w_shamt;
  logic [DW-1:0]            w_alu;
  logic                     w_is_mul;
  logic                     w_a_neg_mul;
  logic                     w_b_neg_mul;
  logic [DW-1:0]            w_a_mag_mul;
  logic [DW-1:0]            w_b_mag_mul;
  logic [2*DW-1:0]          w_acc_nxt;
  logic [2*DW-1:0]          w_prod;
  logic [DW-1:0]            w_mul_res;

  assign w_a     = bus.SrcA;
  assign w_b     = bus.SrcB;
  assign w_shamt = w_b[SW-1:0];

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.ALUResult = r_result;
  assign bus.Busy      = r_busy;

  // Single-cycle operation decode; unlisted codes produce zero.
  always_comb begin
    w_alu = '0;
    case (bus.Operation)
      OP_AND:   w_alu = w_a & w_b;
      OP_XOR:   w_alu = w_a ^ w_b;
      OP_SUB:   w_alu = w_a - w_b;
      OP_OR:    w_alu = w_a | w_b;
      OP_ADD:   w_alu = w_a + w_b;
      OP_SGE:   w_alu = {{(DW-1){1'b0}}, ($signed(w_a) >= $signed(w_b))};
      OP_NE:    w_alu = {{(DW-1){1'b0}}, (w_a != w_b)};
      OP_SRA:   w_alu = DW'($signed(w_a) >>> w_shamt);
      OP_EQ:    w_alu = {{(DW-1){1'b0}}, (w_a == w_b)};
      OP_SLL:   w_alu = w_a << w_shamt;
      OP_PASSB: w_alu = w_b;
      OP_SRL:   w_alu = w_a >> w_shamt;
      OP_SLT:   w_alu = {{(DW-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLTU:  w_alu = {{(DW-1){1'b0}}, (w_a < w_b)};
      default:  w_alu = '0;
    endcase
  end

  // Multiplier works on magnitudes; signedness of each operand depends on the variant.
  assign w_is_mul    = (bus.Operation == OP_MUL) || (bus.Operation == OP_MULH) ||
                       (bus.Operation == OP_MULHSU) || (bus.Operation == OP_MULHU);
  assign w_a_neg_mul = ((bus.Operation == OP_MULH) || (bus.Operation == OP_MULHSU)) && w_a[DW-1];
  assign w_b_neg_mul = (bus.Operation == OP_MULH) && w_b[DW-1];
  assign w_a_mag_mul = w_a_neg_mul ? (~w_a + 1'b1) : w_a;
  assign w_b_mag_mul = w_b_neg_mul ? (~w_b + 1'b1) : w_b;
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : {(2*DW){1'b0}});
  assign w_prod      = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_mul_res   = (r_op == OP_MUL) ? w_prod[DW-1:0] : w_prod[2*DW-1:DW];

`ifdef ALU_MDU_DIV_EN
  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_dmag;
  logic          r_q_neg;
  logic          r_r_neg;

  logic          w_is_div;
  logic          w_div_signed;
  logic          w_div_is_rem;
  logic          w_a_neg_div;
  logic          w_b_neg_div;
  logic          w_div_zero;
  logic          w_div_ovf;
  logic [DW:0]   w_shift;
  logic          w_ge;
  logic [DW-1:0] w_sub;
  logic [DW-1:0] w_rem_nxt;
  logic [DW-1:0] w_quo_nxt;
  logic [DW-1:0] w_div_res;

  assign w_div_signed = (bus.Operation == OP_DIV) || (bus.Operation == OP_REM);
  assign w_div_is_rem = (bus.Operation == OP_REM) || (bus.Operation == OP_REMU);
  assign w_is_div     = w_div_signed || (bus.Operation == OP_DIVU) || (bus.Operation == OP_REMU);
  assign w_a_neg_div  = w_div_signed && w_a[DW-1];
  assign w_b_neg_div  = w_div_signed && w_b[DW-1];
  assign w_div_zero   = (w_b == '0);
  assign w_div_ovf    = w_div_signed && (w_a == {1'b1, {(DW-1){1'b0}}}) && (w_b == '1);

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  assign w_shift   = {r_rem, r_quo[DW-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dmag});
  assign w_sub     = w_shift[DW-1:0] - r_dmag;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[DW-1:0];
  assign w_quo_nxt = {r_quo[DW-2:0], w_ge};
  assign w_div_res = ((r_op == OP_REM) || (r_op == OP_REMU)) ?
                     (r_r_neg ? (~w_rem_nxt + 1'b1) : w_rem_nxt) :
                     (r_q_neg ? (~w_quo_nxt + 1'b1) : w_quo_nxt);

  // Divider datapath registers: loaded at accept, stepped once per cycle in DIV.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dmag  <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.in_valid && w_is_div) begin
      r_quo   <= w_a_neg_div ? (~w_a + 1'b1) : w_a;
      r_rem   <= '0;
      r_dmag  <= w_b_neg_div ? (~w_b + 1'b1) : w_b;
      r_q_neg <= w_a_neg_div ^ w_b_neg_div;
      r_r_neg <= w_a_neg_div;
    end else if (r_state == S_DIV) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
    end
  end
`endif

  // Control FSM, multiplier datapath and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op <= bus.Operation;
            if (w_is_mul) begin
              r_mcand  <= {{DW{1'b0}}, w_a_mag_mul};
              r_mplier <= w_b_mag_mul;
              r_acc    <= '0;
              r_neg    <= w_a_neg_mul ^ w_b_neg_mul;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end
`ifdef ALU_MDU_DIV_EN
            else if (w_is_div) begin
              if (w_div_zero) begin
                r_result    <= w_div_is_rem ? w_a : {DW{1'b1}};
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
              end else if (w_div_ovf) begin
                r_result    <= w_div_is_rem ? {DW{1'b0}} : w_a;
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
              end else begin
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= S_DIV;
              end
            end
`endif
            else begin
              r_result    <= w_alu;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_result    <= w_mul_res;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
`ifdef ALU_MDU_DIV_EN
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_result    <= w_div_res;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors with a scoreboard queue and a decoupled monitor.
// Divider vectors are selected by ALU_MDU_DIV_EN, matching the RTL build.
module tb_alu_mdu;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  alu_mdu_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) bus ();

  alu_mdu #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Busy-cycle counter sampled mid-cycle.
  always @(negedge clk) if (bus.Busy) busy_cnt <= busy_cnt + 1;

  // Monitor: every output handshake pops one expectation and compares it.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got %h expected none", bus.ALUResult);
      end else begin
        e = sb_q.pop_front();
        if (bus.ALUResult !== e.res) begin
          errors++;
          $display("FAIL %s got %h expected %h", e.name, bus.ALUResult, e.res);
        end
        if (e.lat != 0) begin
          checks++;
          if ((cyc - e.acc) != e.lat) begin
            errors++;
            $display("FAIL %s_latency got %0d expected %0d", e.name, cyc - e.acc, e.lat);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Present one operation, wait for accept, optionally record its expectation.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name,
                       input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout got in_ready 0 expected 1", name);
    end else if (push) begin
      e.res = exp; e.lat = lat; e.acc = cyc; e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.SrcA     = 32'h5A5A_5A5A;
    bus.SrcB     = 32'hA5A5_A5A5;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout got %0d pending expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.SrcA      = 32'h0;
    bus.SrcB      = 32'h0;
    bus.Operation = 5'b00000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_result", bus.ALUResult, 32'h0);
    chk("rst_busy", {31'h0, bus.Busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // Single-cycle operations
    issue(5'b00100, 32'd7,          32'd5,          32'd12,         1, "add",    1'b1);
    issue(5'b00111, 32'h8000_0000,  32'h0000_0404,  32'hF800_0000,  1, "sra",    1'b1);
    issue(5'b00010, 32'd5,          32'd7,          32'hFFFF_FFFE,  1, "sub",    1'b1);
    issue(5'b00000, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1, "and",    1'b1);
    issue(5'b00001, 32'hF0F0_0000,  32'hFF00_0000,  32'h0FF0_0000,  1, "xor",    1'b1);
    issue(5'b00011, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1, "or",     1'b1);
    issue(5'b00101, 32'hFFFF_FFFF,  32'h0000_0001,  32'h0,          1, "sge",    1'b1);
    issue(5'b00110, 32'd3,          32'd3,          32'h0,          1, "ne",     1'b1);
    issue(5'b01000, 32'd3,          32'd3,          32'h1,          1, "eq",     1'b1);
    issue(5'b01001, 32'h0000_0001,  32'h0000_0021,  32'h0000_0002,  1, "sll",    1'b1);
    issue(5'b01010, 32'h1111_1111,  32'hCAFE_BABE,  32'hCAFE_BABE,  1, "passb",  1'b1);
    issue(5'b01100, 32'h8000_0000,  32'h0000_001F,  32'h0000_0001,  1, "srl",    1'b1);
    issue(5'b01110, 32'hFFFF_FFFF,  32'h0000_0001,  32'h1,          1, "slt",    1'b1);
    issue(5'b01111, 32'hFFFF_FFFF,  32'h0000_0001,  32'h0,          1, "sltu",   1'b1);
    issue(5'b01011, 32'd9,          32'd9,          32'h0,          1, "unsup",  1'b1);

    // Multiplier
    issue(5'b10000, 32'd3,          32'd4,          32'd12,         33, "mul",    1'b1);
    issue(5'b10000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  33, "mul_neg", 1'b1);
    issue(5'b10001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          33, "mulh",   1'b1);
    issue(5'b10010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33, "mulhsu", 1'b1);
    drain("mul");
    @(negedge clk);
    busy_cnt = 0;
    issue(5'b10011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, "mulhu",  1'b1);
    drain("mulhu");
    chk("mulhu_busy_cycles", busy_cnt, 32'd32);

`ifdef ALU_MDU_DIV_EN
    issue(5'b10100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div",    1'b1);
    issue(5'b10110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem",    1'b1);
    issue(5'b10101, 32'd100,        32'd7,          32'd14,         33, "divu",   1'b1);
    issue(5'b10111, 32'd100,        32'd7,          32'd2,          33, "remu",   1'b1);
    issue(5'b10101, 32'd10,         32'd0,          32'hFFFF_FFFF,  1,  "divu_z", 1'b1);
    issue(5'b10111, 32'd10,         32'd0,          32'd10,         1,  "remu_z", 1'b1);
    issue(5'b10100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf", 1'b1);
    issue(5'b10110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1,  "rem_ovf", 1'b1);
`else
    issue(5'b10100, 32'd9,          32'd3,          32'h0,          1,  "div_off", 1'b1);
    issue(5'b10110, 32'd9,          32'd3,          32'h0,          1,  "rem_off", 1'b1);
`endif
    drain("ops");

    // Backpressure: hold result, ignore in_valid while in DONE
    bus.out_ready = 1'b0;
    issue(5'b00100, 32'd3, 32'd4, 32'd7, 0, "bp_add", 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result_stable", bus.ALUResult, 32'd7);
      chk("bp_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
      bus.Operation = 5'b00100;
      bus.SrcA      = 32'd100;
      bus.SrcB      = 32'd100;
      bus.in_valid  = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("bp");
    repeat (4) @(negedge clk);

    // Reset in the middle of a multiply
    issue(5'b10000, 32'd6, 32'd7, 32'd42, 33, "mul_abort", 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("abort_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("abort_result", bus.ALUResult, 32'h0);
    chk("abort_busy", {31'h0, bus.Busy}, 32'h0);
    reset = 1'b0;
    issue(5'b00100, 32'd1, 32'd1, 32'd2, 1, "add_after_abort", 1'b1);
    drain("abort");
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
